// File: rtl/uart_cfg_ctrl.sv
// uart_cfg_ctrl: parses checksummed 4-byte config frames from uart_rx into baud changes and register writes
module uart_cfg_ctrl #(
  parameter logic [2:0] DEF_BAUD = 3'd0,
  parameter int TIMEOUT_CYC = 250000,
  parameter int GUARD_CYC = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_dat,
  input  logic       rx_ok,
  output logic [2:0] baud_sel,
  output logic       reg_we,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] err_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GUARD_CYC + 1);
  typedef enum logic [1:0] {IDLE, CMD, ARG, CHK} state_t;
  state_t state_q, state_d;
  logic [7:0] cmd_q, arg_q, sum;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] guard_cnt;
  logic guard_act;
  logic [2:0] pend_baud;
  logic timeout, acc_baud, acc_reg, rej;
  logic [1:0] rej_code;
  assign sum = 8'hA5 + cmd_q + arg_q;
  assign timeout = state_q != IDLE && !rx_ok && to_cnt == TW'(TIMEOUT_CYC - 1);
  // next-state and frame verdict; a timeout only fires when no byte arrives that cycle
  always_comb begin
    state_d = state_q;
    acc_baud = 1'b0;
    acc_reg = 1'b0;
    rej = 1'b0;
    rej_code = 2'd0;
    if (timeout) begin
      state_d = IDLE;
      rej = 1'b1;
      rej_code = 2'd2;
    end else if (rx_ok) begin
      case (state_q)
        IDLE: state_d = rx_dat == 8'hA5 ? CMD : IDLE;
        CMD: state_d = ARG;
        ARG: state_d = CHK;
        default: begin
          state_d = IDLE;
          acc_baud = rx_dat == sum && cmd_q == 8'h01;
          acc_reg = rx_dat == sum && cmd_q[7:4] == 4'h1;
          rej = rx_dat != sum || !(cmd_q == 8'h01 || cmd_q[7:4] == 4'h1);
          rej_code = rx_dat != sum ? 2'd1 : 2'd3;
        end
      endcase
    end
  end
  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // frame fields, inter-byte timer and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= '0;
      arg_q <= '0;
      to_cnt <= '0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      reg_we <= 1'b0;
      reg_addr <= '0;
      reg_wdata <= '0;
      err_code <= '0;
      err_cnt <= '0;
    end else begin
      if (rx_ok && state_q == CMD) cmd_q <= rx_dat;
      if (rx_ok && state_q == ARG) arg_q <= rx_dat;
      to_cnt <= (state_q == IDLE || rx_ok || timeout) ? '0 : to_cnt + 1'b1;
      frame_ok <= acc_baud | acc_reg;
      frame_err <= rej;
      reg_we <= acc_reg;
      if (acc_reg) begin
        reg_addr <= cmd_q[3:0];
        reg_wdata <= arg_q;
      end
      if (rej) begin
        err_code <= rej_code;
        err_cnt <= err_cnt + {7'd0, err_cnt != 8'hFF};
      end
    end
  end
  // guarded baud switch-over; a fresh set-baud acceptance beats a coinciding expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_sel <= DEF_BAUD;
      pend_baud <= DEF_BAUD;
      guard_act <= 1'b0;
      guard_cnt <= '0;
    end else if (acc_baud) begin
      pend_baud <= arg_q[2:0];
      guard_act <= 1'b1;
      guard_cnt <= '0;
    end else if (guard_act) begin
      guard_cnt <= guard_cnt + 1'b1;
      if (guard_cnt == GW'(GUARD_CYC - 1)) begin
        guard_act <= 1'b0;
        baud_sel <= pend_baud;
      end
    end
  end
endmodule

// File: doc/uart_cfg_ctrl.md
# uart_cfg_ctrl

Command-frame controller behind the UART receiver. It consumes the received byte stream (`rx_dat`/`rx_ok`), parses fixed 4-byte configuration frames, and validates each frame's checksum. It drives the shared baud select of the UART rx/tx pair, with a guarded switch-over, and issues single-cycle writes to a 16-entry control register bank. It sits between `uart_rx` and the board control registers, and is the only block allowed to change the baud selection.

## Interface
- `DEF_BAUD`, 3'd0, baud select loaded at reset (code 0 = 9600).
- `TIMEOUT_CYC`, 250000, inter-byte timeout in clk cycles (10 ms at 25 MHz).
- `GUARD_CYC`, 5208, delay from accepted set-baud frame to `baud_sel` update (2 bit times at 9600).
- `clk` input 1 system clock.
- `rst` input 1 synchronous, active-high reset.
- `rx_dat` input 8 received byte, valid only when `rx_ok`=1.
- `rx_ok` input 1 one-cycle strobe, one per received byte.
- `baud_sel` output 3 baud code to `uart_rx`/`uart_tx` `rx_baud`.
- `reg_we` output 1 one-cycle register write strobe.
- `reg_addr` output 4 register address, valid with `reg_we`.
- `reg_wdata` output 8 register data, valid with `reg_we`.
- `frame_ok` output 1 one-cycle pulse, frame accepted.
- `frame_err` output 1 one-cycle pulse, frame rejected.
- `err_code` output 2 cause of last rejection: 1 checksum, 2 timeout, 3 unknown command. Holds until the next error.
- `err_cnt` output 8 rejected-frame count, saturates at 255.

## Operation
- Frame format: `0xA5`, `CMD`, `ARG`, `CHK`, where `CHK = (0xA5 + CMD + ARG) mod 256` (8-bit wrap).
- FSM states and transitions, all advancing only on `rx_ok`:
  - `IDLE`: `0xA5` -> `CMD`. Any other byte is discarded silently (no error, no count).
  - `CMD`: latch `CMD` -> `ARG`.
  - `ARG`: latch `ARG` -> `CHK`.
  - `CHK`: compare, execute or reject -> `IDLE`.
- No resync: `0xA5` received in `CMD`/`ARG`/`CHK` is treated as ordinary data.
- Command decode, applied only when the checksum matches:
  - `CMD=0x01`, set baud: `pend_baud <= ARG[2:0]`. Start the guard counter; on expiry `baud_sel <= pend_baud`. `ARG[7:3]` is ignored.
  - `CMD=0x10..0x1F`, register write: `reg_addr=CMD[3:0]`, `reg_wdata=ARG`, `reg_we` pulsed.
  - Any other `CMD`: reject with code 3.
- Checksum mismatch: reject with code 1. No command side effect.
- Timeout:
  - The inter-byte counter runs in `CMD`, `ARG` and `CHK` and clears on every `rx_ok`.
  - Reaching `TIMEOUT_CYC-1` with no `rx_ok` rejects the frame with code 2 and returns to `IDLE`.
  - The counter is held at 0 in `IDLE`.
- Reject actions: `frame_err` pulse, `err_code` updated, `err_cnt` incremented (held at 255 when saturated).
- Accept actions: `frame_ok` pulse. `err_code` and `err_cnt` are unchanged.
- Guard counter: runs independently of the FSM, so parsing continues during the guard. A new accepted set-baud frame while a guard is pending reloads `pend_baud` and restarts the guard from 0.

## Timing
- Reset values: `baud_sel=DEF_BAUD`, `reg_we=0`, `reg_addr=0`, `reg_wdata=0`, `frame_ok=0`, `frame_err=0`, `err_code=0`, `err_cnt=0`, FSM=`IDLE`, no pending baud.
- Reset mid-frame or mid-guard abandons the frame and the pending baud change; `baud_sel` returns to `DEF_BAUD`.
- All outputs are registered.
- `frame_ok`/`frame_err`/`reg_we` assert exactly 1 cycle after the `rx_ok` carrying `CHK`, or on the cycle after the timeout count is reached.
- `baud_sel` changes exactly `GUARD_CYC` cycles after the `frame_ok` cycle of the set-baud frame.
- `rx_ok` in the same cycle the timeout count is reached: the byte is accepted and no timeout occurs.
- Guard expiry coinciding with a new set-baud acceptance: the new acceptance wins. The guard restarts and `baud_sel` is not updated that cycle.
- `rx_ok` is sampled every cycle; back-to-back strobes are legal and each is consumed.

## Test plan
- Reset, then `A5 12 3C F3` -> one `reg_we` with `reg_addr=2`, `reg_wdata=0x3C`; `frame_ok`=1 one cycle; `err_cnt=0`.
- `A5 01 07 AD` -> `frame_ok`. `baud_sel` stays 0 for `GUARD_CYC-1` cycles, then becomes 7. Send a second `A5 01 04 AA` mid-guard -> guard restarts; final `baud_sel=4`; 7 is never driven.
- `A5 12 3C 00` -> `frame_err`, `err_code=1`, `err_cnt=1`, no `reg_we`. Then `A5 77 00 1C` -> `err_code=3`, `err_cnt=2`.
- `A5 12` then idle `TIMEOUT_CYC` cycles -> `frame_err`, `err_code=2`. Repeat with `rx_ok` landing on the final count cycle -> no error.
- Garbage `00 FF 5A` in `IDLE` -> no pulses, `err_cnt` unchanged. 256 checksum errors -> `err_cnt` holds 255.
- Assert `rst` after `A5 01 03` and during a pending guard -> all outputs at reset values. Subsequent valid frame parses normally.
